// File: rtl/sram2sramlike_bridge.sv
// Bridge from a hold-until-done SRAM-style pipeline port to an sram-like
// request/handshake bus. A flushed access whose response is still in flight is
// counted so that the matching late data_ok can be discarded.
module sram2sramlike_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DROP_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // pipeline side
    input  logic                  sram_en,
    input  logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_W/8-1:0]   sram_wen,
    input  logic [DATA_W-1:0]     sram_wdata,
    output logic [DATA_W-1:0]     sram_rdata,
    output logic                  stall,
    input  logic                  longest_stall,
    input  logic                  flush,
    // sram-like side
    output logic                  req,
    output logic                  wr,
    output logic [1:0]            size,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  addr_ok,
    input  logic                  data_ok
);

    localparam int                BE_W     = DATA_W / 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [DROP_W-1:0] w_drop_cnt_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic              w_capture;
    logic              w_drop_zero;
    logic              w_drop_full;

    assign w_drop_zero = (r_drop_cnt == '0);
    assign w_drop_full = (r_drop_cnt == DROP_MAX);

    // A new request is only offered from IDLE and only while another stale
    // response can still be tracked.
    assign req   = sram_en & ~flush & (r_state == S_IDLE) & ~w_drop_full;
    assign stall = sram_en & ~flush & (r_state != S_DONE);
    assign wr    = |sram_wen;
    assign addr  = sram_addr;
    assign wdata = sram_wdata;
    assign sram_rdata = r_rdata;

    // Transfer size from the byte-enable pattern; reads use full width.
    always_comb begin
        if ($onehot(sram_wen))
            size = 2'd0;
        else if (sram_wen == BE_W'(4'b0011) || sram_wen == BE_W'(4'b1100))
            size = 2'd1;
        else
            size = 2'd2;
    end

    // Next-state, stale-response counter and capture decision.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_drop_cnt_nxt = r_drop_cnt;
        w_capture      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (data_ok && !w_drop_zero)
                    w_drop_cnt_nxt = r_drop_cnt - DROP_ONE;
                if (req && addr_ok)
                    w_state_nxt = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (flush) begin
                    // Without a same-cycle data_ok our response is still
                    // owed; with one, it either was ours (dropped) or a stale
                    // one retires while ours becomes stale: net zero.
                    w_state_nxt = S_IDLE;
                    if (!data_ok && !w_drop_full)
                        w_drop_cnt_nxt = r_drop_cnt + DROP_ONE;
                end else if (data_ok) begin
                    if (w_drop_zero) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_drop_cnt_nxt = r_drop_cnt - DROP_ONE;
                    end
                end
            end
            S_DONE: begin
                if (data_ok && !w_drop_zero)
                    w_drop_cnt_nxt = r_drop_cnt - DROP_ONE;
                if (!longest_stall || flush)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and stale-response counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state    <= S_IDLE;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    // Read data holder; updated only by our own captured response.
    always_ff @(posedge clk) begin
        // NOTE: this is a single data register, not a memory array, so it is
        // reset to give the pipeline a defined value after reset.
        if (rst)
            r_rdata <= '0;
        else if (w_capture)
            r_rdata <= rdata;
    end

endmodule

// File: tb/tb_sram2sramlike_bridge.sv
// Self-checking bench: directed scenarios followed by randomized traffic, all
// compared against a transaction-level reference model.
module tb_sram2sramlike_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_en;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wen;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stall;
    logic        longest_stall;
    logic        flush;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    sram2sramlike_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .sram_en      (sram_en),
        .sram_addr    (sram_addr),
        .sram_wen     (sram_wen),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .stall        (stall),
        .longest_stall(longest_stall),
        .flush        (flush),
        .req          (req),
        .wr           (wr),
        .size         (size),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .addr_ok      (addr_ok),
        .data_ok      (data_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an outstanding-access flag, a "result delivered,
    // waiting for pipeline to move" flag, the number of responses still owed
    // to abandoned accesses, and the last delivered read data.
    localparam int M_MAX = 3;
    int          m_owed;
    bit          m_busy;
    bit          m_held;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_size(input logic [3:0] be);
        if ($countones(be) == 1) return 2'd0;
        if (be == 4'b0011 || be == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    task automatic model_reset();
        m_owed  = 0;
        m_busy  = 1'b0;
        m_held  = 1'b0;
        m_rdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sram_en = 1'b0; sram_wen = 4'h0; flush = 1'b0; longest_stall = 1'b0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        sram_addr = 32'h0; sram_wdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs after the falling edge, compare outputs, then
    // advance the model to what the coming rising edge should produce.
    task automatic cycle(input bit en, input logic [3:0] be, input bit fl, input bit ls,
                         input bit aok, input bit dok, input logic [31:0] rd);
        bit exp_req;
        bit exp_stall;
        @(negedge clk);
        sram_en = en; sram_wen = be; flush = fl; longest_stall = ls;
        addr_ok = aok; data_ok = dok; rdata = rd;
        sram_addr = $urandom; sram_wdata = $urandom;
        #1;
        exp_req   = en && !fl && !m_busy && !m_held && (m_owed != M_MAX);
        exp_stall = en && !fl && !m_held;
        check("req",        {31'b0, req},   {31'b0, exp_req});
        check("stall",      {31'b0, stall}, {31'b0, exp_stall});
        check("wr",         {31'b0, wr},    {31'b0, (be != 4'h0)});
        check("size",       {30'b0, size},  {30'b0, ref_size(be)});
        check("sram_rdata", sram_rdata,     m_rdata);
        check("addr",       addr,           sram_addr);
        check("wdata",      wdata,          sram_wdata);
        if (m_held) begin
            if (dok && m_owed > 0) m_owed--;
            if (!ls || fl) m_held = 1'b0;
        end else if (m_busy) begin
            if (fl) begin
                if (!dok) m_owed = (m_owed < M_MAX) ? m_owed + 1 : M_MAX;
                m_busy = 1'b0;
            end else if (dok) begin
                if (m_owed == 0) begin
                    m_rdata = rd;
                    m_busy  = 1'b0;
                    m_held  = 1'b1;
                end else begin
                    m_owed--;
                end
            end
        end else begin
            if (dok && m_owed > 0) m_owed--;
            if (exp_req && aok) m_busy = 1'b1;
        end
    endtask

    initial begin
        do_reset();
        // Reset state.
        cycle(0, 4'h0, 0, 0, 0, 0, 32'h0);
        check("rst_req",   {31'b0, req},   32'd0);
        check("rst_rdata", sram_rdata,     32'h0);

        // Read: request accepted, response two cycles later, stall drops.
        cycle(1, 4'h0, 0, 0, 1, 0, 32'h0);
        check("rd_req_c1", {31'b0, req}, 32'd1);
        cycle(1, 4'h0, 0, 0, 0, 0, 32'h0);
        check("rd_req_c2", {31'b0, req}, 32'd0);
        cycle(1, 4'h0, 0, 0, 0, 1, 32'hDEADBEEF);
        cycle(1, 4'h0, 0, 0, 0, 0, 32'h0);
        check("rd_stall_done", {31'b0, stall}, 32'd0);
        cycle(0, 4'h0, 0, 0, 0, 0, 32'h0);
        check("rd_data", sram_rdata, 32'hDEADBEEF);

        // Write size encodings.
        cycle(0, 4'b1100, 0, 0, 0, 0, 32'h0);
        check("wr_1100",   {31'b0, wr},   32'd1);
        check("size_1100", {30'b0, size}, 32'd1);
        cycle(0, 4'b0100, 0, 0, 0, 0, 32'h0);
        check("size_0100", {30'b0, size}, 32'd0);
        cycle(0, 4'b1111, 0, 0, 0, 0, 32'h0);
        check("size_1111", {30'b0, size}, 32'd2);

        // Completion held by longest_stall must not re-issue the access.
        cycle(1, 4'h0, 0, 0, 1, 0, 32'h0);
        cycle(1, 4'h0, 0, 0, 0, 1, 32'hA5A5A5A5);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4'h0, 0, 1, 0, 0, 32'h0);
            check("hold_req",   {31'b0, req},   32'd0);
            check("hold_stall", {31'b0, stall}, 32'd0);
        end
        cycle(1, 4'h0, 0, 0, 0, 0, 32'h0);
        cycle(1, 4'h0, 0, 0, 0, 0, 32'h0);
        check("hold_next_req", {31'b0, req}, 32'd1);

        // Flushed access: its late response is dropped, the next one kept.
        cycle(1, 4'h0, 0, 0, 1, 0, 32'h0);
        cycle(1, 4'h0, 1, 0, 0, 0, 32'h0);
        cycle(1, 4'h0, 0, 0, 1, 0, 32'h0);
        cycle(1, 4'h0, 0, 0, 0, 1, 32'h11111111);
        cycle(1, 4'h0, 0, 0, 0, 1, 32'h22222222);
        cycle(0, 4'h0, 0, 0, 0, 0, 32'h0);
        check("drop_keep", sram_rdata, 32'h22222222);

        // Flush together with data_ok and nothing owed: nothing captured.
        cycle(1, 4'h0, 0, 0, 1, 0, 32'h0);
        cycle(1, 4'h0, 1, 0, 0, 1, 32'h33333333);
        cycle(1, 4'h0, 0, 0, 0, 0, 32'h0);
        check("fl_dok_req",   {31'b0, req}, 32'd1);
        check("fl_dok_rdata", sram_rdata,   32'h22222222);

        // Saturated stale counter blocks req until one stale response.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 4'h0, 0, 0, 1, 0, 32'h0);
            cycle(1, 4'h0, 1, 0, 0, 0, 32'h0);
        end
        cycle(1, 4'h0, 0, 0, 1, 0, 32'h0);
        check("sat_block", {31'b0, req}, 32'd0);
        cycle(1, 4'h0, 0, 0, 0, 1, 32'h44444444);
        cycle(1, 4'h0, 0, 0, 0, 0, 32'h0);
        check("sat_release", {31'b0, req}, 32'd1);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 8,
                      ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
                      $urandom_range(0, 11) == 0,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) < 3,
                      $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
